// File: rtl/fifo_sync_cfg_pkg.sv
// Shared constants for the single-clock FIFO: read-mode encodings and depth helper.
package fifo_sync_cfg_pkg;

    localparam int FWFT_STD  = 0;  // registered read, latency 1
    localparam int FWFT_FALL = 1;  // head word shown combinationally

    // Number of entries addressed by an asize-bit address.
    function automatic int fifo_depth(input int asize);
        return 1 << asize;
    endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// DEPTH x DSIZE flop storage: one synchronous write port, one asynchronous read port.
module fifo_sync_mem
    import fifo_sync_cfg_pkg::*;
#(
    parameter int DSIZE = 16,
    parameter int ASIZE = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    localparam int DEPTH = fifo_depth(ASIZE);

    // Storage is never reset; stale words are unreachable once the pointers reset.
    logic [DSIZE-1:0] mem_q [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_sync_cfg.sv
// Single-clock FIFO with selectable registered/FWFT read, programmable almost
// thresholds, exact fill count and sticky overflow/underflow flags.
module fifo_sync_cfg
    import fifo_sync_cfg_pkg::*;
#(
    parameter int DSIZE     = 16,
    parameter int ASIZE     = 5,
    parameter int FWFT      = FWFT_STD,
    parameter int AFULL_TH  = (1 << ASIZE) - 2,
    parameter int AEMPTY_TH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    input  logic             rinc,
    input  logic             clr_err,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             rempty,
    output logic             wfull_almost,
    output logic             rempty_almost,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int DEPTH = fifo_depth(ASIZE);

    // Parameter legality, reported at elaboration.
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
        $error("fifo_sync_cfg: AFULL_TH must be in 1..DEPTH");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
        $error("fifo_sync_cfg: AEMPTY_TH must be in 0..DEPTH-1");
    end
    if (FWFT != FWFT_STD && FWFT != FWFT_FALL) begin : g_bad_fwft
        $error("fifo_sync_cfg: FWFT must be 0 or 1");
    end

    localparam logic [ASIZE:0] DEPTH_C  = DEPTH[ASIZE:0];
    localparam logic [ASIZE:0] AFULL_C  = AFULL_TH[ASIZE:0];
    localparam logic [ASIZE:0] AEMPTY_C = AEMPTY_TH[ASIZE:0];

    logic [ASIZE:0]   wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             we, re;
    logic [DSIZE-1:0] mem_rdata;

    // Flags decode the registered count, so they hold steady through the cycle.
    assign wfull         = (count_q == DEPTH_C);
    assign rempty        = (count_q == '0);
    assign wfull_almost  = (count_q >= AFULL_C);
    assign rempty_almost = (count_q <= AEMPTY_C);
    assign count         = count_q;
    assign overflow      = ovf_q;
    assign underflow     = unf_q;

    // A full FIFO still drains and an empty one still fills, so simultaneous
    // requests at the extremes fall out of these two terms directly.
    assign we = winc & ~wfull;
    assign re = rinc & ~rempty;

    // Next-state for pointers, count and sticky errors (set beats clear).
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (we) wptr_d = wptr_q + 1'b1;
        if (re) rptr_d = rptr_q + 1'b1;
        if (we && !re)      count_d = count_q + 1'b1;
        else if (re && !we) count_d = count_q - 1'b1;
        if (winc && wfull)  ovf_d = 1'b1;
        else if (clr_err)   ovf_d = 1'b0;
        if (rinc && rempty) unf_d = 1'b1;
        else if (clr_err)   unf_d = 1'b0;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    fifo_sync_mem #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (wptr_q[ASIZE-1:0]),
        .wdata (wdata),
        .raddr (rptr_q[ASIZE-1:0]),
        .rdata (mem_rdata)
    );

    if (FWFT == FWFT_FALL) begin : g_fwft
        // Head word is visible whenever anything is stored.
        assign rdata = rempty ? '0 : mem_rdata;
    end else begin : g_std
        logic [DSIZE-1:0] rdata_q;
        // Capture the head word on an accepted read; hold otherwise.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)  rdata_q <= '0;
            else if (re) rdata_q <= mem_rdata;
        end
        assign rdata = rdata_q;
    end

endmodule

// File: tb/tb_fifo_sync_cfg.sv
// Drives one stimulus stream into a standard-read and an FWFT instance and checks
// both against a queue-based reference model after every clock.
module tb_fifo_sync_cfg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] wdata;
    logic        winc, rinc, clr_err;

    logic [15:0] s_rdata, f_rdata;
    logic        s_wfull, s_rempty, s_afull, s_aempty, s_ovf, s_unf;
    logic        f_wfull, f_rempty, f_afull, f_aempty, f_ovf, f_unf;
    logic [3:0]  s_count, f_count;

    fifo_sync_cfg #(.DSIZE(16), .ASIZE(3), .FWFT(0), .AFULL_TH(6), .AEMPTY_TH(1)) u_std (
        .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .rinc(rinc), .clr_err(clr_err),
        .rdata(s_rdata), .wfull(s_wfull), .rempty(s_rempty), .wfull_almost(s_afull),
        .rempty_almost(s_aempty), .count(s_count), .overflow(s_ovf), .underflow(s_unf));

    fifo_sync_cfg #(.DSIZE(16), .ASIZE(3), .FWFT(1), .AFULL_TH(6), .AEMPTY_TH(1)) u_fw (
        .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .rinc(rinc), .clr_err(clr_err),
        .rdata(f_rdata), .wfull(f_wfull), .rempty(f_rempty), .wfull_almost(f_afull),
        .rempty_almost(f_aempty), .count(f_count), .overflow(f_ovf), .underflow(f_unf));

    always #5 clk = ~clk;

    // Reference model: contents as a queue, errors as plain bits, registered read word.
    logic [15:0] mq[$];
    logic        m_ovf, m_unf;
    logic [15:0] m_std_rd;
    int          n_pass = 0, n_total = 0;
    string       tag;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s/%s observed=%0h expected=%0h", tag, name, obs, exp);
    endtask

    task automatic check_all();
        int n = mq.size();
        chk("s_count",  32'(s_count),  32'(n));
        chk("f_count",  32'(f_count),  32'(n));
        chk("s_wfull",  32'(s_wfull),  32'(n == 8));
        chk("f_wfull",  32'(f_wfull),  32'(n == 8));
        chk("s_rempty", 32'(s_rempty), 32'(n == 0));
        chk("f_rempty", 32'(f_rempty), 32'(n == 0));
        chk("s_afull",  32'(s_afull),  32'(n >= 6));
        chk("f_afull",  32'(f_afull),  32'(n >= 6));
        chk("s_aempty", 32'(s_aempty), 32'(n <= 1));
        chk("f_aempty", 32'(f_aempty), 32'(n <= 1));
        chk("s_ovf",    32'(s_ovf),    32'(m_ovf));
        chk("f_ovf",    32'(f_ovf),    32'(m_ovf));
        chk("s_unf",    32'(s_unf),    32'(m_unf));
        chk("f_unf",    32'(f_unf),    32'(m_unf));
        chk("s_rdata",  32'(s_rdata),  32'(m_std_rd));
        chk("f_rdata",  32'(f_rdata),  (n == 0) ? 32'h0 : 32'(mq[0]));
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_std_rd = '0;
    endtask

    // One clock of stimulus; the model advances using pre-edge fullness/emptiness.
    task automatic step(input logic w, input logic [15:0] wd, input logic r, input logic c);
        bit full, empty;
        @(negedge clk);
        winc = w; wdata = wd; rinc = r; clr_err = c;
        full  = (mq.size() == 8);
        empty = (mq.size() == 0);
        @(posedge clk);
        if (r && !empty) m_std_rd = mq.pop_front();
        if (w && !full)  mq.push_back(wd);
        if (w && full)   m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
        if (r && empty)  m_unf = 1'b1; else if (c) m_unf = 1'b0;
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; winc = 0; rinc = 0; clr_err = 0; wdata = '0;
        model_reset();
        #12;
        tag = "reset";
        check_all();
        @(negedge clk); rst_n = 1'b1;

        tag = "fill";
        for (int i = 1; i <= 8; i++) step(1, 16'(i), 0, 0);
        tag = "ovf";
        step(1, 16'hDEAD, 0, 0);
        tag = "drain";
        for (int i = 0; i < 8; i++) step(0, 16'h0, 1, 0);
        tag = "unf";
        step(0, 16'h0, 1, 0);
        tag = "clr";
        step(0, 16'h0, 0, 1);

        tag = "full_wr_rd";
        for (int i = 1; i <= 8; i++) step(1, 16'(i), 0, 0);
        step(1, 16'h1234, 1, 0);
        for (int i = 0; i < 7; i++) step(0, 16'h0, 1, 0);
        tag = "empty_wr_rd";
        step(1, 16'h5A5A, 1, 0);
        step(0, 16'h0, 1, 1);

        tag = "fwft_single";
        step(1, 16'hBEEF, 0, 0);
        step(0, 16'h0, 0, 0);
        step(0, 16'h0, 1, 0);

        tag = "wrap";
        for (int i = 0; i < 3; i++) step(1, 16'($urandom), 0, 0);
        for (int i = 0; i < 20; i++) step(1, 16'($urandom), 1, 0);

        tag = "random";
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0));

        tag = "async_rst";
        while (mq.size() < 5) step(1, 16'($urandom), 0, 0);
        while (mq.size() > 5) step(0, 16'h0, 1, 0);
        step(1, 16'h0, 0, 0);            // pushes to full-ish so ovf may be set below
        while (mq.size() < 8) step(1, 16'($urandom), 0, 0);
        step(1, 16'hDEAD, 0, 0);         // overflow set before the reset
        while (mq.size() > 5) step(0, 16'h0, 1, 0);
        @(negedge clk); winc = 0; rinc = 0; clr_err = 0;
        #2 rst_n = 1'b0;                 // mid-cycle, away from any edge
        #1 model_reset();
        check_all();
        @(negedge clk); rst_n = 1'b1;

        tag = "clr_vs_ovf";
        for (int i = 0; i < 8; i++) step(1, 16'(i + 100), 0, 0);
        step(1, 16'hDEAD, 0, 1);
        step(0, 16'h0, 0, 1);

        @(negedge clk); winc = 0; rinc = 0; clr_err = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
